// File: rtl/edge_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// edge_evt_pkg
// Shared definitions for the edge event arbiter:
//   - default channel count and the derived channel-index width
//   - FSM state encoding for the offer state machine
//   - rr_pick: round-robin selection over a request vector
// ---------------------------------------------------------------------------
package edge_evt_pkg;

    localparam int N_CH_DEF = 4;
    localparam int ID_W_DEF = $clog2(N_CH_DEF);

    // Channel count is capped at 16, so the picker works on 16-bit vectors.
    localparam int N_CH_MAX = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // Return the first set bit of pend, searching ptr, ptr+1, ... and
    // wrapping modulo n. Returns 0 when nothing is set (the caller only
    // uses the result when at least one request is present).
    function automatic logic [3:0] rr_pick(input logic [15:0] pend,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = 4'd0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_CH_MAX; k++) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (!found && pend[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// edge_evt_if
// Valid/ready event handshake between the arbiter and its consumer.
//   evt_valid : event offered (producer -> consumer)
//   evt_id    : channel index of the offered event (producer -> consumer)
//   evt_ready : consumer accepts when high together with evt_valid
// Modports: master = arbiter side, slave = consumer side.
// ---------------------------------------------------------------------------
interface edge_evt_if
    import edge_evt_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter_edge_detect_cell.sv
// ---------------------------------------------------------------------------
// edge_detect_cell
// Rising-edge detector for one channel.
//   clk, rstn : clock, async active-low reset
//   in_bit    : level input, synchronous to clk
//   en_bit    : channel enable; masks the rise output
//   rise      : combinational, high for the cycle where in_bit is 1 and
//               was 0 on the previous clock
// The previous-value register resets to 1 so a level already high when
// reset releases is not mistaken for an edge.
// ---------------------------------------------------------------------------
module edge_detect_cell (
    input  logic clk,
    input  logic rstn,
    input  logic in_bit,
    input  logic en_bit,
    output logic rise
);

    logic prev_r;

    // Track the input level from the previous clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= in_bit;
        end
    end

    assign rise = in_bit & ~prev_r & en_bit;

endmodule

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
// Latches rising edges on N_CH level inputs as pending events and serves
// them round-robin to one consumer over a valid/ready handshake.
//   clk, rstn : clock, async active-low reset
//   in_sig    : level inputs (N_CH)
//   ch_en     : per-channel enable; 0 masks detection and clears pending
//   evt       : handshake interface (evt_valid, evt_id, evt_ready)
//   pending   : latched events not yet offered
//   overflow  : sticky, edge arrived while channel already pending
//   ovf_clr   : pulse, clears all overflow bits (a same-cycle set wins)
//   evt_cnt   : accepted handshakes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int ID_W  = $clog2(N_CH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_CH-1:0]  in_sig,
    input  logic [N_CH-1:0]  ch_en,
    edge_evt_if.master       evt,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  overflow,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] evt_cnt
);

    logic [N_CH-1:0]  rise_s;
    logic [N_CH-1:0]  req_s;
    logic [N_CH-1:0]  grant_s;
    logic [ID_W-1:0]  winner_s;

    arb_state_t       state_r, state_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic [ID_W-1:0]  id_r, id_nxt_s;
    logic [ID_W-1:0]  ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [N_CH-1:0]  pend_r, pend_nxt_s;
    logic [N_CH-1:0]  ovf_r, ovf_nxt_s;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_edge
            edge_detect_cell u_cell (
                .clk    (clk),
                .rstn   (rstn),
                .in_bit (in_sig[g]),
                .en_bit (ch_en[g]),
                .rise   (rise_s[g])
            );
        end
    endgenerate

    // Only enabled pending channels compete for the grant.
    assign req_s    = pend_r & ch_en;
    assign winner_s = ID_W'(rr_pick(16'(req_s), 4'(ptr_r), N_CH));

    // Offer FSM: next state, handshake outputs, pointer, counter, grant.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = valid_r;
        id_nxt_s    = id_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        grant_s     = {N_CH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_s != {N_CH{1'b0}}) begin
                    id_nxt_s    = winner_s;
                    valid_nxt_s = 1'b1;
                    grant_s     = {{(N_CH-1){1'b0}}, 1'b1} << winner_s;
                    state_nxt_s = ST_OFFER;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_OFFER: begin
                // The offer is never withdrawn, even if ch_en drops.
                if (evt.evt_ready) begin
                    valid_nxt_s = 1'b0;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    state_nxt_s = ST_IDLE;
                    if (int'(id_r) == N_CH - 1) begin
                        ptr_nxt_s = {ID_W{1'b0}};
                    end else begin
                        ptr_nxt_s = id_r + ID_W'(1);
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Pending and overflow next values; a rise beats a grant clear and an
    // overflow set beats ovf_clr.
    always_comb begin
        pend_nxt_s = pend_r;
        if (ovf_clr) begin
            ovf_nxt_s = {N_CH{1'b0}};
        end else begin
            ovf_nxt_s = ovf_r;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_en[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else if (rise_s[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else if (grant_s[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
            if (rise_s[i] && pend_r[i] && !grant_s[i]) begin
                ovf_nxt_s[i] = 1'b1;
            end else begin
                ovf_nxt_s[i] = ovf_nxt_s[i];
            end
        end
    end

    // State, handshake and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            id_r    <= {ID_W{1'b0}};
            ptr_r   <= {ID_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= {N_CH{1'b0}};
            ovf_r   <= {N_CH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= valid_nxt_s;
            id_r    <= id_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pend_r  <= pend_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign evt.evt_valid = valid_r;
    assign evt.evt_id    = id_r;
    assign pending       = pend_r;
    assign overflow      = ovf_r;
    assign evt_cnt       = cnt_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
// Directed, table-driven bench for edge_event_arbiter (N_CH=4). Each table
// row gives the inputs for one clock and the outputs expected just after
// that clock edge. Reset behaviour is exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;
    import edge_evt_pkg::*;

    localparam int N_CH  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rstn;
    logic [N_CH-1:0]  in_sig;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  overflow;
    logic             ovf_clr;
    logic [CNT_W-1:0] evt_cnt;

    edge_evt_if #(.ID_W(ID_W)) evt_bus ();

    edge_event_arbiter #(.N_CH(N_CH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_sig   (in_sig),
        .ch_en    (ch_en),
        .evt      (evt_bus.master),
        .pending  (pending),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .evt_cnt  (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in_sig;
        logic [3:0]  ch_en;
        logic        ready;
        logic        clr;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [3:0]  exp_pend;
        logic [3:0]  exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;

    function automatic vec_t mk(logic [3:0] i, logic [3:0] e, logic r, logic c,
                                logic v, logic [1:0] id, logic [3:0] p,
                                logic [3:0] o, logic [15:0] n);
        vec_t t;
        t.in_sig = i; t.ch_en = e; t.ready = r; t.clr = c;
        t.exp_valid = v; t.exp_id = id; t.exp_pend = p; t.exp_ovf = o; t.exp_cnt = n;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int row, input logic v,
                           input logic [1:0] id, input logic [3:0] p,
                           input logic [3:0] o, input logic [15:0] n);
        chk({tag, "_valid"}, row, 32'(evt_bus.evt_valid), 32'(v));
        chk({tag, "_id"},    row, 32'(evt_bus.evt_id),    32'(id));
        chk({tag, "_pend"},  row, 32'(pending),           32'(p));
        chk({tag, "_ovf"},   row, 32'(overflow),          32'(o));
        chk({tag, "_cnt"},   row, 32'(evt_cnt),           32'(n));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        in_sig = 4'b0010;
        ch_en  = 4'b1111;
        ovf_clr = 1'b0;
        evt_bus.evt_ready = 1'b0;

        // Reset values, then release with ch1 already high: no event.
        #3;
        chk_all("rst", 0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'd0);
        tick(); tick();
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("held_pend",  c, 32'(pending),           32'd0);
            chk("held_valid", c, 32'(evt_bus.evt_valid), 32'd0);
        end

        // Three simultaneous rises, ptr=0 -> ids 0,1,3, two cycles apart.
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'd0));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 4'b0000, 16'd0));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1010, 4'b0000, 16'd0));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000, 16'd1));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1000, 4'b0000, 16'd1));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000, 16'd2));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 16'd2));
        tbl.push_back(mk(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd3));
        // Single rise on ch2: pending after k, valid after k+1, handshake k+2.
        tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0000, 16'd3));
        tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 16'd3));
        tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 16'd4));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 16'd4));
        // ch1 offered with ready low; two ch3 pulses -> overflow[3].
        tbl.push_back(mk(4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 16'd4));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 16'd4));
        tbl.push_back(mk(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000, 4'b0000, 16'd4));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000, 4'b0000, 16'd4));
        tbl.push_back(mk(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000, 4'b1000, 16'd4));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b1000, 16'd5));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b1000, 16'd5));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        // ch0 masked: pulses ignored; re-enabled pulse -> id 0.
        tbl.push_back(mk(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'd7));

        for (int r = 0; r < tbl.size(); r++) begin
            in_sig            = tbl[r].in_sig;
            ch_en             = tbl[r].ch_en;
            evt_bus.evt_ready = tbl[r].ready;
            ovf_clr           = tbl[r].clr;
            tick();
            chk_all("tbl", r, tbl[r].exp_valid, tbl[r].exp_id, tbl[r].exp_pend,
                    tbl[r].exp_ovf, tbl[r].exp_cnt);
        end
        ovf_clr = 1'b0;

        // Reset mid-offer of ch1 (ptr=1): the offer drops immediately.
        evt_bus.evt_ready = 1'b0;
        in_sig = 4'b0010;
        tick();
        in_sig = 4'b0000;
        tick();
        chk("pre_rst_valid", 0, 32'(evt_bus.evt_valid), 32'd1);
        chk("pre_rst_id",    0, 32'(evt_bus.evt_id),    32'd1);
        #2;
        in_sig = 4'b0010;
        rstn = 1'b0;
        #1;
        chk_all("mid_rst", 0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'd0);
        tick();
        #2;
        rstn = 1'b1;
        evt_bus.evt_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_all("post_rst", c, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
